// File: rtl/spi_master.sv
// SPI master (mode 0, MSB first, 8-bit frames) exposed as an MMIO slave.
// Registers: CTRL {div, cs}, STATUS {ovr, rx_valid, busy}, DATA (tx on write, rx on read).
module spi_master #(
    parameter logic [7:0] DIV_RESET = 8'd124
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        bmmio_cvalid_spi,
    output logic        spi_cready,
    input  logic        bmmio_cmd,
    input  logic [5:0]  bmmio_addr,
    input  logic        bmmio_wvalid_spi,
    output logic        spi_wready,
    input  logic [31:0] bmmio_wdata,
    output logic        spi_rvalid,
    input  logic        bmmio_rready_spi,
    output logic [31:0] spi_rdata,
    output logic        spi_error,
    input  logic        bmmio_eack_spi,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;

    state_t      state, state_next;
    logic [5:0]  addr_q;
    logic [7:0]  div;
    logic        cs;
    logic        busy, rx_valid, ovr;
    logic [7:0]  rx, shreg, cnt;
    logic [2:0]  bit_cnt;
    logic [31:0] rd_mux;

    logic cmd_beat, cmd_fault, wr_stall, wr_beat, wr_ok, rd_beat, rd_data_clr, tick, done;
    logic unused_wdata;

    assign unused_wdata = ^bmmio_wdata[31:16];

    assign cmd_beat    = bmmio_cvalid_spi & spi_cready;
    assign cmd_fault   = bmmio_addr > 6'd2;
    // CTRL/DATA writes wait for the shifter so div/cs never change mid-frame
    assign wr_stall    = busy & ((addr_q == 6'd0) | (addr_q == 6'd2));
    assign wr_beat     = (state == WDATA) & bmmio_wvalid_spi & ~wr_stall;
    assign wr_ok       = wr_beat & (addr_q <= 6'd2);
    assign rd_beat     = (state == RDATA) & bmmio_rready_spi;
    assign rd_data_clr = rd_beat & (addr_q == 6'd2);
    assign tick        = busy & (cnt == 8'd0);
    assign done        = tick & spi_sclk & (bit_cnt == 3'd7);
    assign spi_cs_n    = ~cs;

    // Read data snapshot source, selected by the incoming command address
    always_comb begin
        rd_mux = 32'd0;
        case (bmmio_addr)
            6'd0:    rd_mux = {16'd0, div, 7'd0, cs};
            6'd1:    rd_mux = {29'd0, ovr, rx_valid, busy};
            6'd2:    rd_mux = {24'd0, rx};
            default: rd_mux = 32'd0;
        endcase
    end

    // Transaction FSM state register
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Transaction FSM next state and handshake outputs
    always_comb begin
        state_next = state;
        spi_cready = 1'b0;
        spi_wready = 1'b0;
        spi_rvalid = 1'b0;
        case (state)
            IDLE: begin
                spi_cready = 1'b1;
                if (bmmio_cvalid_spi) state_next = bmmio_cmd ? RDATA : WDATA;
            end
            WDATA: begin
                spi_wready = ~wr_stall;
                if (wr_beat) state_next = IDLE;
            end
            RDATA: begin
                spi_rvalid = 1'b1;
                if (bmmio_rready_spi) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch command address and capture read data at the command beat
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= 6'd0;
            spi_rdata <= 32'd0;
        end else if (cmd_beat) begin
            addr_q <= bmmio_addr;
            if (bmmio_cmd) spi_rdata <= rd_mux;
        end
    end

    // Fault flag: set on a bad command beat, which beats a same-cycle acknowledge
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n)                  spi_error <= 1'b0;
        else if (cmd_beat & cmd_fault) spi_error <= 1'b1;
        else if (bmmio_eack_spi)       spi_error <= 1'b0;
    end

    // CTRL register
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            div <= DIV_RESET;
            cs  <= 1'b0;
        end else if (wr_ok && addr_q == 6'd0) begin
            div <= bmmio_wdata[15:8];
            cs  <= bmmio_wdata[0];
        end
    end

    // Shift engine: half-period counter, sample on rising, shift out on falling
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b1;
            shreg    <= 8'd0;
            cnt      <= 8'd0;
            bit_cnt  <= 3'd0;
        end else if (wr_ok && addr_q == 6'd2) begin
            busy     <= 1'b1;
            shreg    <= bmmio_wdata[7:0];
            spi_mosi <= bmmio_wdata[7];
            spi_sclk <= 1'b0;
            cnt      <= div;
            bit_cnt  <= 3'd0;
        end else if (busy) begin
            if (cnt == 8'd0) begin
                cnt      <= div;
                spi_sclk <= ~spi_sclk;
                if (!spi_sclk) begin
                    shreg <= {shreg[6:0], spi_miso};
                end else if (bit_cnt == 3'd7) begin
                    busy     <= 1'b0;
                    spi_mosi <= 1'b1;
                end else begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    spi_mosi <= shreg[7];
                end
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Receive buffer and status flags; a completing frame wins over a DATA read clear
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            rx       <= 8'd0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (done) begin
                rx       <= shreg;
                rx_valid <= 1'b1;
            end else if (rd_data_clr) begin
                rx_valid <= 1'b0;
            end
            if (done && rx_valid && !rd_data_clr)
                ovr <= 1'b1;
            else if (wr_ok && addr_q == 6'd1 && bmmio_wdata[2])
                ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: bus tasks push expected read data, a monitor
// compares on every cycle rvalid is up; a pin sampler records SCLK edges and MOSI bits.
module tb_spi_master;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        bmmio_cvalid_spi, bmmio_cmd, bmmio_wvalid_spi, bmmio_rready_spi, bmmio_eack_spi;
    logic [5:0]  bmmio_addr;
    logic [31:0] bmmio_wdata;
    logic        spi_cready, spi_wready, spi_rvalid, spi_error;
    logic [31:0] spi_rdata;
    logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;
    logic        miso_loop, miso_inv;

    always #5 clk_core = ~clk_core;

    spi_master #(.DIV_RESET(8'd124)) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .bmmio_cvalid_spi(bmmio_cvalid_spi), .spi_cready(spi_cready),
        .bmmio_cmd(bmmio_cmd), .bmmio_addr(bmmio_addr),
        .bmmio_wvalid_spi(bmmio_wvalid_spi), .spi_wready(spi_wready),
        .bmmio_wdata(bmmio_wdata), .spi_rvalid(spi_rvalid),
        .bmmio_rready_spi(bmmio_rready_spi), .spi_rdata(spi_rdata),
        .spi_error(spi_error), .bmmio_eack_spi(bmmio_eack_spi),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );

    assign spi_miso = miso_loop ? (spi_mosi ^ miso_inv) : 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          tog_q[$];
    logic        mosi_q[$];
    logic        prev_sclk = 1'b0;

    // Reference model state
    logic [7:0] m_div = 8'd124;
    logic       m_cs = 1'b0;
    logic [7:0] m_rx = 8'd0;
    logic       m_rxv = 1'b0;
    logic       m_ovr = 1'b0;

    always @(posedge clk_core) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pin sampler: cycle of every SCLK change, MOSI value at each rising edge
    always @(negedge clk_core) begin
        if (spi_sclk !== prev_sclk) begin
            tog_q.push_back(cyc);
            if (spi_sclk === 1'b1) mosi_q.push_back(spi_mosi);
        end
        prev_sclk = spi_sclk;
    end

    // Monitor: rdata must equal the head expectation whenever rvalid is up; pop on beat
    always @(negedge clk_core) begin
        if (reset_n && spi_rvalid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got rdata=%h expected no read", spi_rdata);
            end else begin
                chk("rdata", spi_rdata, exp_q[0]);
                if (bmmio_rready_spi) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic wait_cready();
        int n = 0;
        while (!spi_cready && n < 200) begin step(); n++; end
        if (!spi_cready) chk("cready_timeout", spi_cready, 1);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int beat);
        int n = 0;
        bmmio_cvalid_spi = 1'b1; bmmio_cmd = 1'b0; bmmio_addr = a;
        wait_cready();
        step();
        bmmio_cvalid_spi = 1'b0; bmmio_wvalid_spi = 1'b1; bmmio_wdata = d;
        while (!spi_wready && n < 5000) begin step(); n++; end
        if (!spi_wready) chk("wready_timeout", spi_wready, 1);
        beat = cyc + 1;
        step();
        bmmio_wvalid_spi = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [31:0] e, input int hold);
        bmmio_cvalid_spi = 1'b1; bmmio_cmd = 1'b1; bmmio_addr = a;
        wait_cready();
        exp_q.push_back(e);
        step();
        bmmio_cvalid_spi = 1'b0;
        chk("rvalid_after_cmd", spi_rvalid, 1);
        for (int i = 0; i < hold; i++) begin
            chk("cready_low_while_pending", spi_cready, 0);
            chk("rvalid_held", spi_rvalid, 1);
            step();
        end
        bmmio_rready_spi = 1'b1;
        step();
        bmmio_rready_spi = 1'b0;
    endtask

    task automatic w_ctrl(input logic [7:0] d, input logic c);
        int beat;
        bus_write(6'd0, {16'd0, d, 7'd0, c}, beat);
        m_div = d;
        m_cs  = c;
    endtask

    task automatic r_ctrl();
        bus_read(6'd0, {16'd0, m_div, 7'd0, m_cs}, 0);
    endtask

    task automatic r_status(input int hold);
        bus_read(6'd1, {29'd0, m_ovr, m_rxv, 1'b0}, hold);
    endtask

    task automatic r_data();
        bus_read(6'd2, {24'd0, m_rx}, 0);
        m_rxv = 1'b0;
    endtask

    function automatic logic [7:0] rx_expect(input logic [7:0] b);
        return miso_loop ? (b ^ {8{miso_inv}}) : 8'h00;
    endfunction

    // One full frame: timing of SCLK edges, MOSI bit order, then model update
    task automatic run_xfer(input logic [7:0] b);
        int beat;
        int half;
        int good;
        logic [7:0] got;
        half = int'(m_div) + 1;
        tog_q.delete();
        mosi_q.delete();
        bus_write(6'd2, {24'd0, b}, beat);
        repeat (16 * half + 3) step();
        chk("sclk_toggle_count", tog_q.size(), 16);
        if (tog_q.size() == 16) begin
            chk("first_edge_delay", tog_q[0] - beat, half);
            chk("transfer_length", tog_q[15] - beat, 16 * half);
            good = 0;
            for (int i = 1; i < 16; i++) if (tog_q[i] - tog_q[i-1] == half) good++;
            chk("sclk_half_periods", good, 15);
        end
        chk("mosi_bit_count", mosi_q.size(), 8);
        if (mosi_q.size() == 8) begin
            got = 8'd0;
            for (int i = 0; i < 8; i++) got = {got[6:0], mosi_q[i]};
            chk("mosi_pattern", got, b);
        end
        chk("sclk_idle", spi_sclk, 0);
        chk("mosi_idle", spi_mosi, 1);
        if (m_rxv) m_ovr = 1'b1;
        m_rx  = rx_expect(b);
        m_rxv = 1'b1;
    endtask

    initial begin
        int b1, b2;
        logic [7:0] by;
        reset_n = 1'b0;
        bmmio_cvalid_spi = 0; bmmio_cmd = 0; bmmio_addr = 0;
        bmmio_wvalid_spi = 0; bmmio_wdata = 0; bmmio_rready_spi = 0; bmmio_eack_spi = 0;
        miso_loop = 1'b1; miso_inv = 1'b0;
        repeat (3) step();
        chk("rst_cready", spi_cready, 1);
        chk("rst_wready", spi_wready, 0);
        chk("rst_rvalid", spi_rvalid, 0);
        chk("rst_rdata", spi_rdata, 0);
        chk("rst_error", spi_error, 0);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 1);
        chk("rst_cs_n", spi_cs_n, 1);
        reset_n = 1'b1;
        step();
        r_ctrl();
        r_status(0);
        r_data();

        // div=0 loopback
        w_ctrl(8'd0, 1'b1);
        chk("cs_n_asserted", spi_cs_n, 0);
        run_xfer(8'hA5);
        r_status(0);
        r_data();
        r_status(0);

        // div=3, MISO tied low
        w_ctrl(8'd3, 1'b1);
        miso_loop = 1'b0;
        run_xfer(8'h3C);
        r_data();
        miso_loop = 1'b1;

        // Back-to-back DATA writes: stall until done, then overrun
        w_ctrl(8'd1, 1'b1);
        miso_inv = 1'b1;
        bus_write(6'd2, 32'h0000_005A, b1);
        bus_write(6'd2, 32'h0000_00C3, b2);
        chk("data_write_stall", b2 - b1, 16 * 2 + 1);
        repeat (16 * 2 + 3) step();
        m_rx = rx_expect(8'hC3); m_rxv = 1'b1; m_ovr = 1'b1;
        r_status(0);
        r_data();
        bus_write(6'd1, 32'h0000_0004, b1);
        m_ovr = 1'b0;
        r_status(0);
        miso_inv = 1'b0;

        // Fault read, error held until acknowledged
        bus_read(6'd3, 32'd0, 0);
        chk("fault_error_set", spi_error, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("error_held", spi_error, 1);
        end
        bmmio_eack_spi = 1'b1;
        step();
        bmmio_eack_spi = 1'b0;
        chk("error_cleared", spi_error, 0);

        // Fault write is discarded
        bus_write(6'h3F, 32'hFFFF_FFFF, b1);
        chk("fault_write_error", spi_error, 1);
        bmmio_eack_spi = 1'b1;
        step();
        bmmio_eack_spi = 1'b0;
        r_ctrl();

        // Read held off by rready
        r_status(4);

        // Randomized frames
        for (int k = 0; k < 6; k++) begin
            w_ctrl(8'($urandom_range(0, 3)), 1'b1);
            miso_inv = 1'($urandom_range(0, 1));
            by = 8'($urandom);
            run_xfer(by);
            r_status(0);
            r_data();
        end
        miso_inv = 1'b0;

        // Reset in the middle of a frame
        w_ctrl(8'd20, 1'b1);
        bus_write(6'd2, 32'h0000_0081, b1);
        repeat (25) step();
        chk("mid_sclk_high", spi_sclk, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_sclk", spi_sclk, 0);
        chk("mid_rst_mosi", spi_mosi, 1);
        chk("mid_rst_cs_n", spi_cs_n, 1);
        chk("mid_rst_cready", spi_cready, 1);
        step();
        reset_n = 1'b1;
        m_div = 8'd124; m_cs = 1'b0; m_rx = 8'd0; m_rxv = 1'b0; m_ovr = 1'b0;
        step();
        r_ctrl();
        r_status(0);

        repeat (4) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
